// File: rtl/facto_arbiter.sv
// Round-robin arbiter that shares one factorial engine among NUM_REQ requesters.
// It rejects negative operands locally and aborts engine jobs that hang past TIMEOUT cycles.
module facto_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [64*NUM_REQ-1:0]   req_oper,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    err,
  output logic [127:0]            rsp_result,
  output logic                    busy,
  output logic                    eng_op_start,
  output logic                    eng_op_clear,
  output logic [63:0]             eng_oper,
  input  logic                    eng_op_done,
  input  logic [127:0]            eng_result
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CLEAR,
    S_REJECT
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   win_q;
  logic [NUM_REQ-1:0] mask_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               err_q;
  logic [127:0]       rsp_result_q;
  logic               busy_q;
  logic               eng_op_start_q;
  logic               eng_op_clear_q;
  logic [63:0]        eng_oper_q;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   win_d;
  logic [NUM_REQ-1:0] win_oh;
  logic [63:0]        sel_oper;
  logic [IDX_W-1:0]   rr_d;

  // Scan from the round-robin pointer; the first eligible index wins.
  always_comb begin
    elig  = req & ~mask_q;
    found = 1'b0;
    idx   = '0;
    win_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(rr_q) + i) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
    win_oh   = NUM_REQ'(1) << win_d;
    sel_oper = req_oper[{win_d, 6'b0} +: 64];
    rr_d     = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      rr_q           <= '0;
      win_q          <= '0;
      mask_q         <= '0;
      cnt_q          <= '0;
      grant_q        <= '0;
      done_q         <= '0;
      err_q          <= 1'b0;
      rsp_result_q   <= '0;
      busy_q         <= 1'b0;
      eng_op_start_q <= 1'b0;
      eng_op_clear_q <= 1'b0;
      eng_oper_q     <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          mask_q <= '0;
          if (found) begin
            win_q   <= win_d;
            grant_q <= win_oh;
            busy_q  <= 1'b1;
            if (sel_oper[63]) begin
              state_q      <= S_REJECT;
              done_q       <= win_oh;
              err_q        <= 1'b1;
              rsp_result_q <= '0;
            end else begin
              state_q        <= S_RUN;
              eng_oper_q     <= sel_oper;
              eng_op_start_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          // Engine completion takes priority over a coincident timeout.
          if (eng_op_done || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            state_q        <= S_CLEAR;
            eng_op_start_q <= 1'b0;
            eng_op_clear_q <= 1'b1;
            done_q         <= grant_q;
            err_q          <= !eng_op_done;
            rsp_result_q   <= eng_op_done ? eng_result : '0;
          end
        end
        S_CLEAR, S_REJECT: begin
          state_q        <= S_IDLE;
          eng_op_clear_q <= 1'b0;
          grant_q        <= '0;
          mask_q         <= grant_q;
          rr_q           <= rr_d;
          cnt_q          <= '0;
          busy_q         <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rsp_result   = rsp_result_q;
  assign busy         = busy_q;
  assign eng_op_start = eng_op_start_q;
  assign eng_op_clear = eng_op_clear_q;
  assign eng_oper     = eng_oper_q;

endmodule

// File: doc/facto_arbiter.md
Name: facto_arbiter

Overview:
Shares one factorial engine (op_start/op_clear/oper/op_done/result handshake) among NUM_REQ requesters.
- Selects requesters round-robin and latches the winner's operand.
- Sequences the engine through start → wait-done → clear.
- Returns the 128-bit result to the winner with a one-cycle done pulse.
- Rejects negative operands without using the engine, and recovers from a hung engine by timeout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 4096, max cycles in RUN before forced abort
IDX_W, 2, width of winner index, must equal clog2(NUM_REQ)

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester level request; operand must be stable while high
req_oper  input  64*NUM_REQ  packed signed operands, requester i at [64*i+63:64*i]
grant  output  NUM_REQ  one-hot, winner of current job, held IDLE-exit through CLEAR
done  output  NUM_REQ  one-cycle pulse to winner when job completes
err  output  1  valid with done; 1 = negative operand or timeout
rsp_result  output  128  result of last completed job, held until next completion
busy  output  1  high in any state except IDLE
eng_op_start  output  1  to engine op_start
eng_op_clear  output  1  to engine op_clear
eng_oper  output  64  to engine oper
eng_op_done  input  1  from engine op_done, held high until op_clear
eng_result  input  128  from engine result, valid while eng_op_done=1

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; rr pointer=0; mask=0; timeout counter=0. Applies mid-job; engine sees start=0 and clear=0. The engine has its own reset, so the arbiter issues no clear after reset.
- States: IDLE, RUN, CLEAR, REJECT.
- Eligibility: eligible = req & ~mask. mask is one-hot of the previous winner for exactly one IDLE cycle after CLEAR/REJECT, else 0. A requester must drop req in the cycle after its done pulse.
- Winner: first eligible index scanning rr, rr+1, ..., wrapping modulo NUM_REQ.
- IDLE:
  - No eligible request: stay in IDLE.
  - Eligible request, winner w: grant[w]=1; capture oper=req_oper[w].
  - oper[63]=1 (negative): go to REJECT.
  - Otherwise: eng_oper<=oper; go to RUN.
- RUN:
  - eng_op_start=1 throughout; counter increments each cycle.
  - eng_op_done=1: rsp_result<=eng_result, err<=0 (registered); go to CLEAR.
  - Counter reaches TIMEOUT-1 without done: rsp_result<=0, err<=1; go to CLEAR.
  - If done and timeout coincide, done wins.
- CLEAR (exactly 1 cycle):
  - eng_op_start=0, eng_op_clear=1, done[w]=1.
  - Next cycle: rr<=w+1 mod NUM_REQ, mask<=onehot(w), grant<=0, counter<=0; go to IDLE.
- REJECT (exactly 1 cycle):
  - done[w]=1, err=1, rsp_result=0; engine untouched (start=0, clear=0).
  - Exit identical to CLEAR.
- Latency (idle engine, operand accepted): request seen in IDLE at cycle t → eng_op_start rises at t+1. done pulses 1 cycle after the cycle in which eng_op_done is sampled high.
- Withdrawn request: dropping req after grant does not cancel the job; it still completes and done still pulses.
- Operand sampling: req_oper changes after grant are ignored; the operand is sampled once in IDLE.
- eng_oper holds its value after job end until the next accepted job.
- rsp_result and err are not cleared by IDLE; they change only on a completion.
- Zero operand is legal and forwarded to the engine (engine returns 1).
- Throughput: at most one job in flight. Minimum job cycle = IDLE + RUN(n) + CLEAR.

Test Plan:
- Single requester: req[0]=1, oper=7, engine model answers 5040 → grant=0001; eng_op_start high until done; one-cycle eng_op_clear; done[0] pulse; rsp_result=5040; err=0.
- Contention: req[1] and req[2] raised in the same cycle with opers 5 and 3, from reset (rr=0) → grant order 1 then 2; results 120 then 6; rr ends at 3.
- Fairness: all four req held high with oper=4 → grants rotate 0,1,2,3,0 and each done carries 24. Then drop req[0] and hold req[1..3]: after the granted job ends, req[0] is never granted; grants continue rotating among 1,2,3.
- Negative operand: req[3]=1, oper=-2 → REJECT; eng_op_start never rises; done[3] pulse with err=1, rsp_result=0.
- Timeout: TIMEOUT=16, engine stub never asserts done → exactly 16 cycles of start; then clear pulse, done with err=1, rsp_result=0.
- Reset mid-RUN: assert reset_n=0 while eng_op_start=1 → all outputs 0 immediately. After release, a new req[2] with oper=6 completes with 720.
